// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline controller: stall encodings, exception codes
// and the redirect-target helper.
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE  = 6'b000000;
  localparam logic [5:0] STALL_IF_ID = 6'b000111;
  localparam logic [5:0] STALL_EX    = 6'b001111;
  localparam logic [5:0] STALL_MEM   = 6'b011111;

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [31:0] EXC_VECTOR_DFLT = 32'h0000_0020;

  localparam logic STOP       = 1'b1;
  localparam logic NO_STOP    = 1'b0;
  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_WAIT_BUS = 1'b1
  } ctrl_state_t;

  // eret returns to EPC; every other nonzero code enters the common vector
  function automatic logic [31:0] exc_target(input logic [31:0] code,
                                             input logic [31:0] epc,
                                             input logic [31:0] vector);
    logic [31:0] target;
    if (code == EXC_ERET) begin
      target = epc;
    end else begin
      target = vector;
    end
    return target;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // count up on inc, stop at the maximum value
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      q_r <= {W{1'b0}};
    end else if (inc && (q_r != {W{1'b1}})) begin
      q_r <= q_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests, turns MEM-stage exceptions into a
// single-cycle flush with redirect PC, deferring it while a bus access is pending.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DFLT,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      excepttype,
  input  logic [31:0]      cp0_epc,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] exc_cnt
);

  ctrl_state_t state_r;
  logic [31:0] exc_type_r;
  logic [31:0] epc_r;
  logic [5:0]  stall_s;
  logic        flush_s;
  logic [31:0] new_pc_s;
  logic        exc_s;

  assign exc_s = (excepttype != EXC_NONE);

  // state and exception latches; the first exception seen wins until it is flushed
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_r    <= ST_RUN;
      exc_type_r <= 32'h0000_0000;
      epc_r      <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (exc_s && stallreq_mem) begin
            state_r    <= ST_WAIT_BUS;
            exc_type_r <= excepttype;
            epc_r      <= cp0_epc;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_WAIT_BUS: begin
          if (stallreq_mem) begin
            state_r <= ST_WAIT_BUS;
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: state_r <= ST_RUN;
      endcase
    end
  end

  // same-cycle stall/flush/redirect decision
  always_comb begin
    stall_s  = STALL_NONE;
    flush_s  = NO_STOP;
    new_pc_s = 32'h0000_0000;
    if (rst == RST_ENABLE) begin
      stall_s = STALL_NONE;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (exc_s) begin
            if (stallreq_mem) begin
              stall_s = STALL_MEM;
            end else begin
              flush_s  = STOP;
              new_pc_s = exc_target(excepttype, cp0_epc, EXC_VECTOR);
            end
          end else if (stallreq_mem) begin
            stall_s = STALL_MEM;
          end else if (stallreq_ex) begin
            stall_s = STALL_EX;
          end else if (stallreq_id || stallreq_if) begin
            stall_s = STALL_IF_ID;
          end else begin
            stall_s = STALL_NONE;
          end
        end
        ST_WAIT_BUS: begin
          if (stallreq_mem) begin
            stall_s = STALL_MEM;
          end else begin
            flush_s  = STOP;
            new_pc_s = exc_target(exc_type_r, epc_r, EXC_VECTOR);
          end
        end
        default: stall_s = STALL_NONE;
      endcase
    end
  end

  assign stall  = stall_s;
  assign flush  = flush_s;
  assign new_pc = new_pc_s;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_s[0]),
    .q   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_exc_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_s),
    .q   (exc_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed vector table for the corner cases, then random
// traffic against a queue-based behavioural model; a 3-bit-counter copy checks saturation.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sif, sid, sex, smem;
  logic [31:0] code, epc;
  logic [5:0]  stall, stall3;
  logic        flush, flush3;
  logic [31:0] new_pc, new_pc3;
  logic [31:0] stall_cnt, exc_cnt;
  logic [2:0]  stall_cnt3, exc_cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl u_dut (
    .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex),
    .stallreq_mem(smem), .excepttype(code), .cp0_epc(epc), .stall(stall),
    .flush(flush), .new_pc(new_pc), .stall_cnt(stall_cnt), .exc_cnt(exc_cnt)
  );

  pipe_ctrl #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .stallreq_if(sif), .stallreq_id(sid), .stallreq_ex(sex),
    .stallreq_mem(smem), .excepttype(code), .cp0_epc(epc), .stall(stall3),
    .flush(flush3), .new_pc(new_pc3), .stall_cnt(stall_cnt3), .exc_cnt(exc_cnt3)
  );

  // behavioural model: pending deferred exceptions and raw event counts
  typedef struct { logic [31:0] code; logic [31:0] epc; } exc_t;
  exc_t   pend_q[$];
  longint m_scnt, m_ecnt;
  logic [5:0]  m_stall;
  logic        m_flush;
  logic [31:0] m_pc;

  typedef struct {
    logic rst, sif, sid, sex, smem;
    logic [31:0] code, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    int          scnt, ecnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic i_f, logic i_d, logic i_e, logic i_m,
                              logic [31:0] c, logic [31:0] e, logic [5:0] st,
                              logic fl, logic [31:0] pc, int sc, int ec);
    vec_t v;
    v.rst = r; v.sif = i_f; v.sid = i_d; v.sex = i_e; v.smem = i_m;
    v.code = c; v.epc = e; v.stall = st; v.flush = fl; v.pc = pc;
    v.scnt = sc; v.ecnt = ec;
    return v;
  endfunction

  function automatic logic [31:0] target(logic [31:0] c, logic [31:0] e);
    return (c == 32'he) ? e : 32'h20;
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval();
    m_stall = 6'b000000; m_flush = 1'b0; m_pc = 32'h0;
    if (rst) begin
      m_stall = 6'b000000;
    end else if (pend_q.size() != 0) begin
      if (smem) m_stall = 6'b011111;
      else begin m_flush = 1'b1; m_pc = target(pend_q[0].code, pend_q[0].epc); end
    end else if (code != 32'h0) begin
      if (smem) m_stall = 6'b011111;
      else begin m_flush = 1'b1; m_pc = target(code, epc); end
    end else if (smem) m_stall = 6'b011111;
    else if (sex) m_stall = 6'b001111;
    else if (sid || sif) m_stall = 6'b000111;
  endtask

  task automatic model_update();
    if (rst) begin
      pend_q.delete(); m_scnt = 0; m_ecnt = 0;
    end else begin
      if (m_flush && pend_q.size() != 0) void'(pend_q.pop_front());
      else if (!m_flush && pend_q.size() == 0 && code != 32'h0 && smem)
        pend_q.push_back('{code, epc});
      m_scnt += longint'(m_stall[0]);
      m_ecnt += longint'(m_flush);
    end
  endtask

  function automatic longint cap(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // one clock: outputs checked mid-cycle, counters checked just after the edge
  task automatic cycle(string tag);
    #1;
    model_eval();
    chk({tag, ".stall"}, stall, m_stall);
    chk({tag, ".flush"}, flush, m_flush);
    if (m_flush || rst) chk({tag, ".new_pc"}, new_pc, m_pc);
    chk({tag, ".stall3"}, stall3, m_stall);
    model_update();
    @(posedge clk); #1;
    chk({tag, ".stall_cnt"}, stall_cnt, cap(m_scnt, 64'hffff_ffff));
    chk({tag, ".exc_cnt"}, exc_cnt, cap(m_ecnt, 64'hffff_ffff));
    chk({tag, ".stall_cnt3"}, stall_cnt3, cap(m_scnt, 7));
    chk({tag, ".exc_cnt3"}, exc_cnt3, cap(m_ecnt, 7));
  endtask

  initial begin
    rst = 1'b1; {sif, sid, sex, smem} = 4'b1111; code = 32'h8; epc = 32'h0;
    m_scnt = 0; m_ecnt = 0;
    //           rst if id ex mem code   epc      stall     fl  pc       sc ec
    tbl.push_back(mk(1, 1, 1, 1, 1, 32'h8, 32'h0,    6'b000000, 0, 32'h0,    0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 32'h0, 32'h0,    6'b011111, 0, 32'h0,    1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'h0, 32'h0,    6'b001111, 0, 32'h0,    2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'h0, 32'h0,    6'b001111, 0, 32'h0,    3, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'h0, 32'h0,    6'b001111, 0, 32'h0,    4, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'hc, 32'h0,    6'b000000, 1, 32'h20,   4, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'he, 32'h1234, 6'b000000, 1, 32'h1234, 4, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 32'h0,    4, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h1, 32'h0,    6'b011111, 0, 32'h0,    5, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h8, 32'hdead, 6'b011111, 0, 32'h0,    6, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h8, 32'hdead, 6'b011111, 0, 32'h0,    7, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h8, 32'hdead, 6'b011111, 0, 32'h0,    8, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h8, 32'hdead, 6'b000000, 1, 32'h20,   8, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 32'h0,    8, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h8, 32'h0,    6'b011111, 0, 32'h0,    9, 3));
    tbl.push_back(mk(1, 0, 0, 0, 0, 32'h8, 32'h0,    6'b000000, 0, 32'h0,    0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h0, 32'h0,    6'b000000, 0, 32'h0,    0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 32'h0, 32'h0,    6'b000111, 0, 32'h0,    1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 32'h0, 32'h0,    6'b000111, 0, 32'h0,    2, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 32'ha, 32'h0,    6'b000000, 1, 32'h20,   2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 32'h5, 32'h77,   6'b000000, 1, 32'h20,   2, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'hd, 32'h0,    6'b011111, 0, 32'h0,    3, 2));
    tbl.push_back(mk(0, 0, 0, 1, 0, 32'h0, 32'h0,    6'b000000, 1, 32'h20,   3, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'he, 32'h4444, 6'b011111, 0, 32'h0,    4, 3));
    tbl.push_back(mk(0, 0, 1, 1, 0, 32'h0, 32'h9999, 6'b000000, 1, 32'h4444, 4, 4));

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; sif = tbl[i].sif; sid = tbl[i].sid; sex = tbl[i].sex;
      smem = tbl[i].smem; code = tbl[i].code; epc = tbl[i].epc;
      #1;
      chk($sformatf("vec%0d.stall", i), stall, tbl[i].stall);
      chk($sformatf("vec%0d.flush", i), flush, tbl[i].flush);
      if (tbl[i].flush || tbl[i].rst) chk($sformatf("vec%0d.new_pc", i), new_pc, tbl[i].pc);
      model_eval();
      model_update();
      @(posedge clk); #1;
      chk($sformatf("vec%0d.stall_cnt", i), stall_cnt, tbl[i].scnt);
      chk($sformatf("vec%0d.exc_cnt", i), exc_cnt, tbl[i].ecnt);
    end

    // saturation: ten stall cycles after reset
    rst = 1'b1; {sif, sid, sex, smem} = 4'b0000; code = 32'h0; epc = 32'h0;
    cycle("sat_rst");
    rst = 1'b0; sif = 1'b1;
    for (int i = 0; i < 10; i++) cycle("sat");
    chk("sat.stall_cnt3_final", stall_cnt3, 7);
    chk("sat.stall_cnt_final", stall_cnt, 10);

    // random traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] codes [7];
      codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h3};
      rst  = ($urandom_range(0, 40) == 0);
      sif  = ($urandom_range(0, 3) == 0);
      sid  = ($urandom_range(0, 3) == 0);
      sex  = ($urandom_range(0, 3) == 0);
      smem = ($urandom_range(0, 2) == 0);
      code = ($urandom_range(0, 5) == 0) ? codes[$urandom_range(0, 6)] : 32'h0;
      epc  = $urandom;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
